ramp_sequencer: RTL and testbench

Command-driven controller that sits directly upstream of the 8-bit up/down counter with load and drives its load, data, enable and up_down inputs. It accepts a (start, target, hold) command over a valid/ready handshake and loads the counter with start. It then ramps the counter one step per clock to target, holds for a programmed number of cycles, and reports completion. An abort input stops the counter immediately and returns the sequencer to idle.

---
 rtl/ramp_sequencer.sv | 124 ++++++++++++
 tb/tb_ramp_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: command-driven controller for an up/down counter with load.
// Loads the counter with a start value, ramps it one step per clock toward a
// target, holds for a programmed number of cycles, then reports completion.
// An abort input stops the counter immediately and returns to idle.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready are both high; cmd_ready is high only in IDLE, and
// the command fields are sampled on that same edge.
module ramp_sequencer #(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_data,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RAMP = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   target_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               dir_q;

  // Sequencer state, captured command, hold counter and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      target_q <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
      dir_q    <= 1'b0;
      cnt_data <= '0;
      aborted  <= 1'b0;
    end else begin
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            target_q <= cmd_target;
            hold_q   <= cmd_hold;
            dir_q    <= (cmd_target >= cmd_start);
            cnt_data <= cmd_start;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The load strobe is already on the counter this cycle, so an
          // abort here still leaves the counter holding start.
          if (abort) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else begin
            cnt_data <= target_q;
            state    <= S_RAMP;
          end
        end
        S_RAMP: begin
          if (abort) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else if (cnt_out == target_q) begin
            hold_cnt <= hold_q;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else if (hold_cnt == '0) begin
            state <= S_DONE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Step request is combinational from cnt_out so the counter stops exactly
  // on target and never wraps, and abort freezes it in the same cycle.
  always_comb begin
    cnt_enable = (state == S_RAMP) && (cnt_out != target_q) && !abort;
  end

  // Remaining outputs are plain decodes of the registered state.
  always_comb begin
    cmd_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    cnt_load    = (state == S_LOAD);
    cnt_up_down = (state == S_RAMP) && dir_q;
    done        = (state == S_DONE);
    state_dbg   = state;
  end

endmodule

// File: tb/tb_ramp_sequencer.sv
// Directed bench for ramp_sequencer with a behavioural up/down counter model
// closing the loop on cnt_out. Cycle numbering: cycle 0 is the cycle whose
// closing edge performs the handshake; cycle 1 is LOAD.
module tb_ramp_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_start;
  logic [7:0] cmd_target;
  logic [7:0] cmd_hold;
  logic       abort;
  logic [7:0] cnt_out = 8'd0;
  logic       cnt_load;
  logic [7:0] cnt_data;
  logic       cnt_enable;
  logic       cnt_up_down;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset block
  always #5 clk = ~clk;

  ramp_sequencer #(.WIDTH(8), .HOLD_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_target (cmd_target),
    .cmd_hold   (cmd_hold),
    .abort      (abort),
    .cnt_out    (cnt_out),
    .cnt_load   (cnt_load),
    .cnt_data   (cnt_data),
    .cnt_enable (cnt_enable),
    .cnt_up_down(cnt_up_down),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .state_dbg  (state_dbg)
  );

  // Downstream 8-bit up/down counter with load.
  always @(posedge clk) begin
    if (cnt_load)        cnt_out <= cnt_data;
    else if (cnt_enable) cnt_out <= cnt_up_down ? cnt_out + 8'd1 : cnt_out - 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full command with checks at every cycle from the handshake to the
  // first idle cycle after done. Returns in that idle cycle.
  task automatic run_cmd(input int s, input int t, input int h);
    int n;
    int dir;
    int exp_out;
    dir = (t >= s) ? 1 : 0;
    n   = dir ? (t - s) : (s - t);
    cmd_valid = 1'b1; cmd_start = s[7:0]; cmd_target = t[7:0]; cmd_hold = h[7:0];
    #1;
    check("c0_ready", cmd_ready, 1);
    tick(); cmd_valid = 1'b0; #1;
    check("load_strobe", cnt_load, 1);
    check("load_data", cnt_data, s);
    check("load_enable", cnt_enable, 0);
    check("load_busy", busy, 1);
    for (int c = 2; c <= n + 2; c++) begin
      tick(); #1;
      exp_out = dir ? (s + c - 2) : (s - c + 2);
      check("ramp_out", cnt_out, exp_out & 255);
      check("ramp_enable", cnt_enable, (c != n + 2) ? 1 : 0);
      check("ramp_dir", cnt_up_down, dir);
      check("ramp_data", cnt_data, t);
      check("ramp_load", cnt_load, 0);
      check("ramp_done", done, 0);
      check("ramp_busy", busy, 1);
    end
    for (int c = n + 3; c <= n + h + 3; c++) begin
      tick(); #1;
      check("hold_enable", cnt_enable, 0);
      check("hold_out", cnt_out, t);
      check("hold_done", done, 0);
      check("hold_busy", busy, 1);
    end
    tick(); #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_ready", cmd_ready, 0);
    tick(); #1;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_ready", cmd_ready, 1);
    check("post_data_hold", cnt_data, t);
    check("post_out", cnt_out, t);
    check("post_enable", cnt_enable, 0);
    check("post_aborted", aborted, 0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_target = '0;
    cmd_hold = '0; abort = 1'b0;
    tick(); tick();
    check("rst_load", cnt_load, 0);
    check("rst_enable", cnt_enable, 0);
    check("rst_dir", cnt_up_down, 0);
    check("rst_data", cnt_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    reset = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1);

    // Up, down, equal-endpoint and full-range ramps
    run_cmd(10, 14, 2);
    run_cmd(200, 195, 0);
    run_cmd(0, 0, 0);
    run_cmd(0, 255, 0);

    // Abort in IDLE is ignored
    abort = 1'b1; #1;
    check("idle_abort_en", cnt_enable, 0);
    tick(); abort = 1'b0; #1;
    check("idle_abort_pulse", aborted, 0);
    check("idle_abort_ready", cmd_ready, 1);

    // Abort mid-RAMP at cycle 20 of 0 -> 100
    cmd_valid = 1'b1; cmd_start = 8'd0; cmd_target = 8'd100; cmd_hold = 8'd3;
    tick(); cmd_valid = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    abort = 1'b1; #1;
    check("abr_c20_out", cnt_out, 18);
    check("abr_c20_enable", cnt_enable, 0);
    check("abr_c20_busy", busy, 1);
    tick(); abort = 1'b0; #1;
    check("abr_c21_pulse", aborted, 1);
    check("abr_c21_busy", busy, 0);
    check("abr_c21_done", done, 0);
    check("abr_c21_out", cnt_out, 18);
    for (int c = 0; c < 6; c++) begin
      tick(); #1;
      check("abr_after_pulse", aborted, 0);
      check("abr_after_done", done, 0);
      check("abr_after_out", cnt_out, 18);
    end

    // Abort during HOLD: 5 -> 7, hold 5, abort in cycle 7
    cmd_valid = 1'b1; cmd_start = 8'd5; cmd_target = 8'd7; cmd_hold = 8'd5;
    tick(); cmd_valid = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    abort = 1'b1; #1;
    check("habr_enable", cnt_enable, 0);
    check("habr_busy", busy, 1);
    tick(); abort = 1'b0; #1;
    check("habr_pulse", aborted, 1);
    check("habr_done", done, 0);
    check("habr_busy_after", busy, 0);
    for (int c = 0; c < 6; c++) begin
      tick(); #1;
      check("habr_no_done", done, 0);
      check("habr_out", cnt_out, 7);
    end

    // Abort during LOAD: load still asserts, counter keeps start
    cmd_valid = 1'b1; cmd_start = 8'd77; cmd_target = 8'd90; cmd_hold = 8'd0;
    tick(); cmd_valid = 1'b0; abort = 1'b1; #1;
    check("labr_load", cnt_load, 1);
    check("labr_enable", cnt_enable, 0);
    tick(); abort = 1'b0; #1;
    check("labr_pulse", aborted, 1);
    check("labr_out", cnt_out, 77);
    tick(); #1;
    check("labr_out_hold", cnt_out, 77);

    // cmd_valid held high while busy: 1 -> 3 hold 0, done in cycle 6
    cmd_valid = 1'b1; cmd_start = 8'd1; cmd_target = 8'd3; cmd_hold = 8'd0;
    tick();
    cmd_start = 8'd50; cmd_target = 8'd52; #1;
    check("hs_c1_data", cnt_data, 1);
    check("hs_c1_ready", cmd_ready, 0);
    for (int c = 2; c <= 6; c++) begin
      tick(); #1;
      check("hs_busy_ready", cmd_ready, 0);
      check("hs_load_low", cnt_load, 0);
    end
    check("hs_c6_done", done, 1);
    tick(); #1;
    check("hs_c7_ready", cmd_ready, 1);
    check("hs_c7_busy", busy, 0);
    tick(); cmd_valid = 1'b0; #1;
    check("hs_c8_load", cnt_load, 1);
    check("hs_c8_data", cnt_data, 50);
    for (int c = 9; c <= 13; c++) tick();
    check("hs_second_done", done, 1);
    check("hs_second_out", cnt_out, 52);
    tick();

    // Reset mid-RAMP: 0 -> 50, reset asserted in cycle 10
    cmd_valid = 1'b1; cmd_start = 8'd0; cmd_target = 8'd50; cmd_hold = 8'd0;
    tick(); cmd_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b0;
    tick(); #1;
    check("mrst_load", cnt_load, 0);
    check("mrst_enable", cnt_enable, 0);
    check("mrst_dir", cnt_up_down, 0);
    check("mrst_data", cnt_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_aborted", aborted, 0);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(); #1;
      check("mrst_no_done", done, 0);
      check("mrst_no_abort", aborted, 0);
      check("mrst_ready", cmd_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
